// File: rtl/eth_axil_master_bridge_pkg.sv
// Shared types for the AXI-lite master bridge: access size encoding, AXI response codes
// and the alignment rule applied to incoming commands.
package eth_axil_master_bridge_pkg;

  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // The reserved size is treated as a bad command, alongside unaligned halves and words.
  function automatic logic cmd_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/eth_axil_lane_align.sv
// Combinational byte-lane steering: write strobes, write-data replication across lanes,
// and read-data right-alignment plus zero-extension to the access size.
module eth_axil_lane_align
  import eth_axil_master_bridge_pkg::*;
(
  input  size_e                   size_i,
  input  logic [1:0]              addr_lo_i,
  input  logic [AXIL_DATA_W-1:0]  wdata_i,
  input  logic [AXIL_DATA_W-1:0]  rdata_i,
  output logic [AXIL_STRB_W-1:0]  wstrb_o,
  output logic [AXIL_DATA_W-1:0]  wdata_o,
  output logic [AXIL_DATA_W-1:0]  rdata_o
);

  logic [AXIL_DATA_W-1:0] rdata_shifted;

  assign rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_shifted;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'b0, rdata_shifted[7:0]};
      end
      SIZE_HALF: begin
        wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'b0, rdata_shifted[15:0]};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_shifted;
      end
    endcase
  end

endmodule

// File: rtl/eth_axil_master_bridge.sv
// Single-outstanding command to AXI-lite master bridge; 3-cycle min accept-to-response, 1 cycle for bad commands.
// cmd_ready_and_o only in IDLE; response held stable until resp_ready_and_i; all AXI valids are state-driven.
module eth_axil_master_bridge
  import eth_axil_master_bridge_pkg::*;
#(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_i,

  input  logic                           cmd_v_i,
  output logic                           cmd_ready_and_o,
  input  logic [axil_addr_width_p-1:0]   cmd_addr_i,
  input  logic                           cmd_wr_en_i,
  input  logic [1:0]                     cmd_data_size_i,
  input  logic [axil_data_width_p-1:0]   cmd_wdata_i,

  output logic                           resp_v_o,
  input  logic                           resp_ready_and_i,
  output logic [axil_data_width_p-1:0]   resp_rdata_o,
  output logic                           resp_err_o,

  output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
  output logic [2:0]                     m_axil_awprot_o,
  output logic                           m_axil_awvalid_o,
  input  logic                           m_axil_awready_i,
  output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
  output logic                           m_axil_wvalid_o,
  input  logic                           m_axil_wready_i,
  input  logic [1:0]                     m_axil_bresp_i,
  input  logic                           m_axil_bvalid_i,
  output logic                           m_axil_bready_o,
  output logic [axil_addr_width_p-1:0]   m_axil_araddr_o,
  output logic [2:0]                     m_axil_arprot_o,
  output logic                           m_axil_arvalid_o,
  input  logic                           m_axil_arready_i,
  input  logic [axil_data_width_p-1:0]   m_axil_rdata_i,
  input  logic [1:0]                     m_axil_rresp_i,
  input  logic                           m_axil_rvalid_i,
  output logic                           m_axil_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_e;

  state_e                         state_r, state_n;
  logic [axil_addr_width_p-1:0]   addr_r;
  size_e                          size_r;
  logic [axil_data_width_p-1:0]   wdata_r;
  logic [axil_data_width_p-1:0]   rdata_r;
  logic                           err_r;
  logic                           aw_done_r, w_done_r;

  logic                           cmd_fire;
  logic                           cmd_bad;
  logic                           aw_hs, w_hs;
  logic [axil_data_width_p-1:0]   rdata_aligned;

  eth_axil_lane_align u_lane_align (
    .size_i    (size_r),
    .addr_lo_i (addr_r[1:0]),
    .wdata_i   (wdata_r),
    .rdata_i   (m_axil_rdata_i),
    .wstrb_o   (m_axil_wstrb_o),
    .wdata_o   (m_axil_wdata_o),
    .rdata_o   (rdata_aligned)
  );

  assign cmd_bad  = cmd_is_bad(cmd_data_size_i, cmd_addr_i[1:0]);
  assign cmd_fire = cmd_v_i && cmd_ready_and_o;

  // Handshakes derived from registered state so the ready inputs never feed a valid.
  assign aw_hs = (state_r == S_WR_REQ) && !aw_done_r && m_axil_awready_i;
  assign w_hs  = (state_r == S_WR_REQ) && !w_done_r  && m_axil_wready_i;

  assign m_axil_awaddr_o = {addr_r[axil_addr_width_p-1:2], 2'b00};
  assign m_axil_araddr_o = {addr_r[axil_addr_width_p-1:2], 2'b00};
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_arprot_o = 3'b000;
  assign resp_rdata_o    = rdata_r;
  assign resp_err_o      = err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n          = state_r;
    cmd_ready_and_o  = 1'b0;
    resp_v_o         = 1'b0;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o  = 1'b0;
    m_axil_bready_o  = 1'b0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o  = 1'b0;
    case (state_r)
      S_IDLE: begin
        cmd_ready_and_o = 1'b1;
        if (cmd_v_i) begin
          if (cmd_bad)          state_n = S_RESP;
          else if (cmd_wr_en_i) state_n = S_WR_REQ;
          else                  state_n = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        m_axil_awvalid_o = !aw_done_r;
        m_axil_wvalid_o  = !w_done_r;
        if ((aw_done_r || aw_hs) && (w_done_r || w_hs)) state_n = S_WR_RESP;
      end
      S_WR_RESP: begin
        m_axil_bready_o = 1'b1;
        if (m_axil_bvalid_i) state_n = S_RESP;
      end
      S_RD_REQ: begin
        m_axil_arvalid_o = 1'b1;
        if (m_axil_arready_i) state_n = S_RD_RESP;
      end
      S_RD_RESP: begin
        m_axil_rready_o = 1'b1;
        if (m_axil_rvalid_i) state_n = S_RESP;
      end
      S_RESP: begin
        resp_v_o = 1'b1;
        if (resp_ready_and_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      addr_r    <= '0;
      size_r    <= SIZE_BYTE;
      wdata_r   <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_r  <= cmd_addr_i;
        size_r  <= size_e'(cmd_data_size_i);
        wdata_r <= cmd_wdata_i;
        rdata_r <= '0;
        err_r   <= cmd_bad;
      end

      if (state_r == S_WR_REQ) begin
        aw_done_r <= aw_done_r || aw_hs;
        w_done_r  <= w_done_r  || w_hs;
      end else begin
        aw_done_r <= 1'b0;
        w_done_r  <= 1'b0;
      end

      if (state_r == S_WR_RESP && m_axil_bvalid_i) begin
        rdata_r <= '0;
        err_r   <= (m_axil_bresp_i != AXI_RESP_OKAY);
      end

      // Read data is captured even on an error response; the error flag tells the consumer.
      if (state_r == S_RD_RESP && m_axil_rvalid_i) begin
        rdata_r <= rdata_aligned;
        err_r   <= (m_axil_rresp_i != AXI_RESP_OKAY);
      end
    end
  end

endmodule

// File: tb/tb_eth_axil_master_bridge.sv
// Directed bench for eth_axil_master_bridge with a configurable-wait AXI-lite slave model.
module tb_eth_axil_master_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_v_i, cmd_ready_and_o, cmd_wr_en_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [1:0]  cmd_data_size_i;
  logic        resp_v_o, resp_ready_and_i, resp_err_o;
  logic [31:0] resp_rdata_o;

  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int          aw_wait, w_wait, ar_wait;
  logic        b_en;
  logic [1:0]  bresp_cfg, rresp_cfg;
  logic [31:0] rdata_cfg;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;

  logic        mon_clr;
  int          aw_cyc, w_cyc, ar_cyc;
  logic [31:0] awaddr_cap, wdata_cap, araddr_cap;
  logic [3:0]  wstrb_cap;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk_i = ~clk_i;

  eth_axil_master_bridge dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .cmd_v_i          (cmd_v_i),
    .cmd_ready_and_o  (cmd_ready_and_o),
    .cmd_addr_i       (cmd_addr_i),
    .cmd_wr_en_i      (cmd_wr_en_i),
    .cmd_data_size_i  (cmd_data_size_i),
    .cmd_wdata_i      (cmd_wdata_i),
    .resp_v_o         (resp_v_o),
    .resp_ready_and_i (resp_ready_and_i),
    .resp_rdata_o     (resp_rdata_o),
    .resp_err_o       (resp_err_o),
    .m_axil_awaddr_o  (awaddr),
    .m_axil_awprot_o  (awprot),
    .m_axil_awvalid_o (awvalid),
    .m_axil_awready_i (awready),
    .m_axil_wdata_o   (wdata),
    .m_axil_wstrb_o   (wstrb),
    .m_axil_wvalid_o  (wvalid),
    .m_axil_wready_i  (wready),
    .m_axil_bresp_i   (bresp),
    .m_axil_bvalid_i  (bvalid),
    .m_axil_bready_o  (bready),
    .m_axil_araddr_o  (araddr),
    .m_axil_arprot_o  (arprot),
    .m_axil_arvalid_o (arvalid),
    .m_axil_arready_i (arready),
    .m_axil_rdata_i   (rdata),
    .m_axil_rresp_i   (rresp),
    .m_axil_rvalid_i  (rvalid),
    .m_axil_rready_o  (rready)
  );

  // Slave model: ready rises after a programmable number of valid cycles.
  assign awready = (aw_cnt >= aw_wait);
  assign wready  = (w_cnt  >= w_wait);
  assign arready = (ar_cnt >= ar_wait);
  assign bresp   = bresp_cfg;
  assign rresp   = rresp_cfg;
  assign rdata   = rdata_cfg;

  always @(posedge clk_i) begin
    if (reset_i) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
    end else begin
      if (awvalid && awready) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= 0; else if (wvalid)  w_cnt  <= w_cnt + 1;
      if (arvalid && arready) ar_cnt <= 0; else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (awvalid && awready) aw_got <= 1'b1;
      if (wvalid && wready)   w_got  <= 1'b1;
      if (bvalid && bready) bvalid <= 1'b0;
      else if (b_en && !bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      else if (arvalid && arready) rvalid <= 1'b1;
    end
  end

  always @(posedge clk_i) begin
    if (mon_clr) begin
      aw_cyc <= 0; w_cyc <= 0; ar_cyc <= 0;
    end else begin
      if (awvalid) aw_cyc <= aw_cyc + 1;
      if (wvalid)  w_cyc  <= w_cyc + 1;
      if (arvalid) ar_cyc <= ar_cyc + 1;
      if (awvalid && awready) awaddr_cap <= awaddr;
      if (wvalid && wready) begin
        wdata_cap <= wdata;
        wstrb_cap <= wstrb;
      end
      if (arvalid && arready) araddr_cap <= araddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one command and returns the number of cycles until resp_v_o is seen (bounded).
  task automatic do_cmd(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                        input logic [31:0] wd, output int cycles);
    @(negedge clk_i);
    cmd_addr_i = addr; cmd_wr_en_i = wr; cmd_data_size_i = size; cmd_wdata_i = wd;
    cmd_v_i = 1'b1; mon_clr = 1'b1;
    @(negedge clk_i);
    cmd_v_i = 1'b0; mon_clr = 1'b0;
    cycles = 1;
    while (!resp_v_o && cycles < 100) begin
      @(negedge clk_i);
      cycles++;
    end
  endtask

  task automatic consume();
    resp_ready_and_i = 1'b1;
    @(negedge clk_i);
    resp_ready_and_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; cmd_v_i = 1'b0; cmd_addr_i = '0; cmd_wr_en_i = 1'b0;
    cmd_data_size_i = 2'd0; cmd_wdata_i = '0; resp_ready_and_i = 1'b0;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_en = 1'b1;
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = '0; mon_clr = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b0; mon_clr = 1'b0;
    @(negedge clk_i);
    chk("rst_cmd_ready", cmd_ready_and_o, 1);
    chk("rst_resp_v", resp_v_o, 0);
    chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_rdata", resp_rdata_o, 0);
    chk("rst_err", resp_err_o, 0);

    // Word write, zero-wait slave
    do_cmd(32'h10, 1'b1, 2'd2, 32'hDEADBEEF, lat);
    chk("ww_lat", lat, 3);
    chk("ww_awaddr", awaddr_cap, 32'h10);
    chk("ww_wstrb", wstrb_cap, 4'hF);
    chk("ww_wdata", wdata_cap, 32'hDEADBEEF);
    chk("ww_prot", {awprot, arprot}, 0);
    chk("ww_err", resp_err_o, 0);
    chk("ww_rdata", resp_rdata_o, 0);
    chk("ww_busy", cmd_ready_and_o, 0);
    consume();
    chk("ww_idle_ready", cmd_ready_and_o, 1);
    chk("ww_resp_drop", resp_v_o, 0);

    // Byte write, awready delayed
    aw_wait = 3;
    do_cmd(32'h13, 1'b1, 2'd0, 32'h000000A5, lat);
    chk("bw_lat", lat, 6);
    chk("bw_awaddr", awaddr_cap, 32'h10);
    chk("bw_wstrb", wstrb_cap, 4'b1000);
    chk("bw_wdata", wdata_cap, 32'hA5A5A5A5);
    chk("bw_aw_cycles", aw_cyc, 4);
    chk("bw_w_cycles", w_cyc, 1);
    chk("bw_err", resp_err_o, 0);
    consume();
    aw_wait = 0;

    // Half write upper half
    do_cmd(32'h12, 1'b1, 2'd1, 32'h1234BEEF, lat);
    chk("hw_wstrb", wstrb_cap, 4'b1100);
    chk("hw_wdata", wdata_cap, 32'hBEEFBEEF);
    consume();

    // Half read, aligned upper half
    rdata_cfg = 32'h1234ABCD;
    do_cmd(32'h22, 1'b0, 2'd1, 32'h0, lat);
    chk("hr_lat", lat, 3);
    chk("hr_araddr", araddr_cap, 32'h20);
    chk("hr_rdata", resp_rdata_o, 32'h00001234);
    chk("hr_err", resp_err_o, 0);
    consume();

    // Byte read lane 1, word read
    do_cmd(32'h11, 1'b0, 2'd0, 32'h0, lat);
    chk("br_rdata", resp_rdata_o, 32'h000000AB);
    consume();
    rdata_cfg = 32'h89ABCDEF;
    do_cmd(32'h14, 1'b0, 2'd2, 32'h0, lat);
    chk("wr_araddr", araddr_cap, 32'h14);
    chk("wr_rdata", resp_rdata_o, 32'h89ABCDEF);
    consume();

    // Misaligned half read: immediate error, no AXI traffic
    do_cmd(32'h21, 1'b0, 2'd1, 32'h0, lat);
    chk("mis_lat", lat, 1);
    chk("mis_err", resp_err_o, 1);
    chk("mis_rdata", resp_rdata_o, 0);
    chk("mis_no_ar", ar_cyc, 0);
    consume();

    // Reserved size and misaligned word write
    do_cmd(32'h0, 1'b1, 2'd3, 32'h0, lat);
    chk("rsvd_lat", lat, 1);
    chk("rsvd_err", resp_err_o, 1);
    chk("rsvd_no_aw", aw_cyc, 0);
    consume();
    do_cmd(32'h2, 1'b1, 2'd2, 32'h0, lat);
    chk("misw_err", resp_err_o, 1);
    chk("misw_no_w", w_cyc, 0);
    consume();

    // Write with slave error
    bresp_cfg = 2'b10;
    do_cmd(32'h30, 1'b1, 2'd2, 32'h11223344, lat);
    chk("bresp_err", resp_err_o, 1);
    consume();
    bresp_cfg = 2'b00;

    // Read error with response stalled five cycles
    rresp_cfg = 2'b10; rdata_cfg = 32'hCAFEF00D;
    do_cmd(32'h0, 1'b0, 2'd2, 32'h0, lat);
    for (int k = 0; k < 5; k++) begin
      chk("stall_resp_v", resp_v_o, 1);
      chk("stall_err", resp_err_o, 1);
      chk("stall_rdata", resp_rdata_o, 32'hCAFEF00D);
      chk("stall_cmd_ready", cmd_ready_and_o, 0);
      @(negedge clk_i);
    end
    consume();
    chk("stall_release", cmd_ready_and_o, 1);
    rresp_cfg = 2'b00;

    // Reset while waiting in WR_RESP
    b_en = 1'b0;
    @(negedge clk_i);
    cmd_addr_i = 32'h40; cmd_wr_en_i = 1'b1; cmd_data_size_i = 2'd2; cmd_wdata_i = 32'h55AA55AA;
    cmd_v_i = 1'b1;
    @(negedge clk_i);
    cmd_v_i = 1'b0;
    @(negedge clk_i);
    chk("rst_in_wr_resp", bready, 1);
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    chk("midrst_valids", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("midrst_cmd_ready", cmd_ready_and_o, 1);
    chk("midrst_resp_v", resp_v_o, 0);
    repeat (3) @(negedge clk_i);
    chk("midrst_no_resp", resp_v_o, 0);
    b_en = 1'b1;

    // Recovery after reset
    do_cmd(32'h44, 1'b1, 2'd2, 32'h0BADF00D, lat);
    chk("post_lat", lat, 3);
    chk("post_wdata", wdata_cap, 32'h0BADF00D);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_axil_master_bridge.md
ETH_AXIL_MASTER_BRIDGE -- requirements
Module: eth_axil_master_bridge

Interface
REQ-001 SHALL have parameter axil_data_width_p, default 32, AXI-lite data width; only 32 supported.
REQ-002 SHALL have parameter axil_addr_width_p, default 32, AXI-lite address width.
REQ-003 SHALL have one clock and reset: clk_i  input  1  sole clock; reset_i  input  1  synchronous, active-high reset.
REQ-004 cmd_v_i  input  1  command valid; cmd_ready_and_o  output  1  command accepted when both high.
REQ-005 cmd_addr_i  input  axil_addr_width_p  byte address; cmd_wr_en_i  input  1  1=write, 0=read.
REQ-006 cmd_data_size_i  input  2  0=byte, 1=half, 2=word, 3=reserved; cmd_wdata_i  input  axil_data_width_p  right-aligned write data.
REQ-007 resp_v_o  output  1  response valid; resp_ready_and_i  input  1  response consumed when both high.
REQ-008 resp_rdata_o  output  axil_data_width_p  right-aligned, zero-extended read data (0 for writes); resp_err_o  output  1  error flag.
REQ-009 SHALL expose full AXI-lite master m_axil_{awaddr,awprot,awvalid,awready,wdata,wstrb,wvalid,wready,bresp,bvalid,bready,araddr,arprot,arvalid,arready,rdata,rresp,rvalid,rready}_{o,i}, standard widths, direction per master role.

Function
REQ-010 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP.
REQ-011 cmd_ready_and_o SHALL equal (state==IDLE); exactly one outstanding transaction.
REQ-012 On accept: write -> WR_REQ, read -> RD_REQ; addr/size/wen/data registered same edge.
REQ-013 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 3 command SHALL go directly to RESP with resp_err_o=1, rdata=0, no AXI traffic.
REQ-014 AXI addresses SHALL be cmd_addr with addr[1:0] cleared; awprot/arprot constant 3'b000.
REQ-015 wstrb: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-016 wdata SHALL replicate the low byte (byte) or low half (half) across all lanes.
REQ-017 WR_REQ: awvalid and wvalid assert first cycle in state; each drops independently after own handshake; both done (incl. same cycle) -> WR_RESP.
REQ-018 WR_RESP: bready=1; on bvalid capture err=(bresp!=2'b00), rdata=0 -> RESP.
REQ-019 RD_REQ: arvalid=1 until arready -> RD_RESP; RD_RESP: rready=1; on rvalid capture rdata shifted right by 8*addr[1:0], masked to size, err=(rresp!=0) -> RESP.
REQ-020 RESP: resp_v_o=1, data/err stable until resp_ready_and_i -> IDLE; new command accepted no earlier than next cycle.
REQ-021 Latency: minimum cmd accept to resp_v_o 3 cycles with zero-wait slave; misaligned path 1 cycle.
REQ-022 valid signals SHALL never depend combinationally on ready inputs; no combinational path cmd_* to m_axil_*.

Reset
REQ-023 reset_i SHALL force state IDLE and all outputs low: cmd_ready_and_o=1 from first cycle after reset release, resp_v_o=0, all m_axil valid/ready=0, resp_rdata_o=0, resp_err_o=0.
REQ-024 Reset mid-transaction SHALL abandon it with no response; system-wide reset of the slave is assumed by design.

Structure
REQ-025 Size encoding enum and AXI resp constants (OKAY=2'b00) SHALL live in the shared package; FSM state enum stays local.
REQ-026 Byte-lane steering (wstrb, wdata replicate, rdata align/mask) SHALL be one sub-module, eth_axil_lane_align, purely combinational.
REQ-027 Sized for 120-400 lines RTL; bsg primitives only, no FIFOs.

Verification
REQ-028 Word write addr 0x10, data 0xDEADBEEF, slave zero-wait -> awaddr 0x10, wstrb 4'hF, resp_err_o=0, resp_v_o 3 cycles after accept.
REQ-029 Byte write addr 0x13 data 0xA5 -> wstrb 4'b1000, wdata 0xA5A5A5A5; awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4.
REQ-030 Half read addr 0x22, slave rdata 0x1234ABCD -> araddr 0x20, resp_rdata_o 0x00001234.
REQ-031 Half read addr 0x21 -> resp_err_o=1 one cycle after accept, no arvalid ever.
REQ-032 Read with rresp=2'b10 and resp_ready_and_i held low 5 cycles -> resp_err_o=1, resp_v_o and data stable 5 cycles, cmd_ready_and_o low throughout.
REQ-033 reset_i pulsed during WR_RESP -> next cycle all valids 0, cmd_ready_and_o=1, no resp_v_o.
